seq_nonrestoring_divider: RTL and testbench
===========================================

Name: seq_nonrestoring_divider

Overview:
- Iterative unsigned non-restoring divider, generalised from the fixed 4-bit CAS row.
- Reuses one parametrised (WIDTH+1)-bit controlled add/subtract row once per clock for WIDTH iterations, then performs a final remainder-restore step.
- Uses a start/busy/done handshake.
- Sits in the arithmetic datapath as the shared division unit.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..32)

Ports:
clk  in  1  sole clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
dividend  in  WIDTH  numerator, captured on accepted start
divisor  in  WIDTH  denominator, captured on accepted start
busy  out  1  high from the edge that accepts start until done is asserted
done  out  1  single-cycle pulse; quotient/remainder valid from this cycle on
quotient  out  WIDTH  result, held until next accepted start
remainder  out  WIDTH  result, held until next accepted start
div_by_zero  out  1  set with done when captured divisor was 0; held with results

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, div_by_zero, quotient, remainder all 0; internal P, A, D, iteration counter cleared. An operation in flight is abandoned and no done pulse is produced.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE + start=1:
  - Capture A=dividend, D=divisor, P=0 (WIDTH+1 bits), cnt=0; busy=1; clear div_by_zero.
  - If divisor==0, go to DONE. Otherwise go to RUN.
- RUN, one iteration per cycle:
  - Shift {P,A} left by 1.
  - If the old P sign bit is 0, P=P-{0,D}; else P=P+{0,D}. This is the CAS control input: subtract when the sign is 0, with carry-in = control.
  - New quotient bit = ~P_new[WIDTH], shifted into A[0].
  - cnt++. After WIDTH iterations, go to FIX.
- FIX: if P[WIDTH]==1, P=P+{0,D}. Then go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - quotient=A; remainder=P[WIDTH-1:0].
  - For divide by zero: quotient=all ones; remainder=captured dividend; div_by_zero=1.
  - busy=0 in the same cycle. Next state is IDLE.
- Latency:
  - Normal: done is visible WIDTH+2 rising edges after the edge that accepted start (10 for WIDTH=8).
  - Divide by zero: done is visible 1 edge after the accepting edge.
- start while busy (RUN/FIX/DONE) is ignored. It is not queued.
- start held high: a new operation is accepted in IDLE, i.e. the cycle after done. Back-to-back throughput is WIDTH+3 cycles.
- Inputs dividend/divisor may change freely after the accepting edge.
- Arithmetic:
  - P is WIDTH+1 bits, two's complement.
  - All add/subtract operations are modulo 2^(WIDTH+1).
  - Remainder is always < divisor and ≥ 0.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- When defined:
  - Operands are two's complement.
  - On accept, magnitudes are captured and the signs latched.
  - An extra SIGN state between FIX and DONE negates quotient if sign(dividend)^sign(divisor), and negates remainder if sign(dividend). Latency becomes WIDTH+3.
  - -2^(WIDTH-1) / -1 gives quotient=-2^(WIDTH-1) (wrap) and remainder=0, with no flag.
  - Divide by zero is unchanged: quotient all ones, remainder=dividend.
- When undefined: unsigned only. The SIGN state and sign registers do not exist.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, RUN, FIX, DONE, SIGN).
  - counter width constant $clog2(WIDTH+1).
  - div-by-zero quotient constant (all ones).
- Sub-module cas_row:
  - Combinational, parametrised N=WIDTH+1.
  - Controlled add/subtract row with ports a, m, ctrl, sum, cout.
  - Instantiated once as the iteration datapath, replacing the fixed 4-cell array.

Test Plan (WIDTH=8):
- 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 10 edges after start edge; busy high for 9 cycles before done.
- 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5 (exercises the FIX restore).
- 37/0 -> done 1 edge after start; quotient=0xFF, remainder=37, div_by_zero=1.
- Assert start with 200/3 at cycle 3 of a running 100/7 operation -> ignored; 100/7 result delivered; start held high afterwards -> 200/3 accepted the cycle after done, giving 66 r 2.
- Assert rst during RUN iteration 4 -> all outputs 0 immediately; no done pulse; next 50/5 gives 10 r 0.
- With SIGNED_DIV_EN: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2), done at 11 edges; -128/-1 -> quotient=0x80, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
// Holds the FSM state encoding, counter sizing and divide-by-zero quotient.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      FIX,
      DONE,
      SIGN
   } state_t;

   localparam int MAX_WIDTH = 32;

   // Quotient reported for a zero divisor; sliced to the operand width.
   localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = '1;

   // Iteration counter width: must hold the value WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/cas_row.sv
// Controlled add/subtract row: sum = a + m when ctrl=0, a - m when ctrl=1.
// The subtract uses the inverted m with carry-in equal to ctrl.
module cas_row #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] m,
   input  logic         ctrl,
   output logic [N-1:0] sum,
   output logic         cout
);

   // Ripple of N controlled add/subtract cells, written as one adder.
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, m ^ {N{ctrl}}} + {{N{1'b0}}, ctrl};
   end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Iterative non-restoring divider, one cas_row pass per clock, then restore.
// Define SIGNED_DIV_EN for two's-complement operands (adds a SIGN state).
module seq_nonrestoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);
   localparam int PW = WIDTH + 1;

   state_t           state_q, state_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [PW-1:0]    p_fix;

   logic [PW-1:0]    cas_a, cas_m, cas_sum;
   logic             cas_ctrl, cas_cout_unused;

`ifdef SIGNED_DIV_EN
   logic             nq_q, nq_d;
   logic             nr_q, nr_d;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
`endif

   cas_row #(.N(PW)) u_cas (
      .a    (cas_a),
      .m    (cas_m),
      .ctrl (cas_ctrl),
      .sum  (cas_sum),
      .cout (cas_cout_unused)
   );

   // Next-state, datapath steering and result capture.
   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      a_d      = a_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      cas_a    = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
      cas_m    = {1'b0, d_q};
      cas_ctrl = ~p_q[WIDTH];
      p_fix    = p_q[WIDTH] ? cas_sum : p_q;
`ifdef SIGNED_DIV_EN
      nq_d     = nq_q;
      nr_d     = nr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               p_d   = '0;
               dbz_d = 1'b0;
`ifdef SIGNED_DIV_EN
               a_d  = mag(dividend);
               d_d  = mag(divisor);
               nq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               nr_d = dividend[WIDTH-1];
`else
               a_d  = dividend;
               d_d  = divisor;
`endif
               if (divisor == '0) begin
                  quot_d  = DBZ_QUOT[WIDTH-1:0];
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            p_d   = cas_sum;
            a_d   = {a_q[WIDTH-2:0], ~cas_sum[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            cas_a    = p_q;
            cas_ctrl = 1'b0;
            p_fix    = p_q[WIDTH] ? cas_sum : p_q;
            p_d      = p_fix;
`ifdef SIGNED_DIV_EN
            state_d  = SIGN;
`else
            quot_d   = a_q;
            rem_d    = p_fix[WIDTH-1:0];
            state_d  = DONE;
`endif
         end
`ifdef SIGNED_DIV_EN
         SIGN: begin
            quot_d  = nq_q ? -a_q : a_q;
            rem_d   = nr_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            state_d = DONE;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         a_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
         nq_q    <= 1'b0;
         nr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         a_q     <= a_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
         nq_q    <= nq_d;
         nr_q    <= nr_d;
`endif
      end
   end

   // Handshake outputs decoded from state; results come from held registers.
   always_comb begin
      busy        = (state_q == RUN) || (state_q == FIX) || (state_q == SIGN);
      done        = (state_q == DONE);
      quotient    = quot_q;
      remainder   = rem_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Directed self-checking bench for seq_nonrestoring_divider (WIDTH=8).
// Compile with SIGNED_DIV_EN defined to check the signed build.
module tb_seq_nonrestoring_divider;

   localparam int W = 8;
`ifdef SIGNED_DIV_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 10;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   seq_nonrestoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present an operation so that the next rising edge accepts it.
   task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv);
      @(negedge clk);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count mid-cycle samples until done, and busy samples before it.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (done) break;
         if (busy) bcnt++;
      end
   endtask

   task automatic op(input string tag, input logic [W-1:0] dd,
                     input logic [W-1:0] dv, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic ez,
                     input int elat, input int ebusy);
      int lat, bcnt;
      issue(dd, dv);
      wait_done(lat, bcnt);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_busy"}, bcnt, ebusy);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, div_by_zero, ez);
      @(negedge clk);
      chk({tag, "_pulse"}, done, 1'b0);
      chk({tag, "_hold"}, quotient, eq);
   endtask

   initial begin
      int lat, bcnt, n, pulses;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", quotient, 8'd0);
      chk("rst_r", remainder, 8'd0);
      chk("rst_dbz", div_by_zero, 1'b0);
      rst = 1'b0;

      op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, LAT - 1);
      op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, LAT - 1);
      op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, LAT, LAT - 1);
      op("d37_0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, 0);
      op("d63_8", 8'd63, 8'd8, 8'd7, 8'd7, 1'b0, LAT, LAT - 1);

      issue(8'd100, 8'd7);
      repeat (3) @(negedge clk);
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd3;
      wait_done(lat, bcnt);
      chk("ign_lat", lat, LAT - 3);
      chk("ign_q", quotient, 8'd14);
      chk("ign_r", remainder, 8'd2);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (n == 2) start = 1'b0;
         if (done) break;
      end
      chk("b2b_gap", n, LAT + 1);
`ifdef SIGNED_DIV_EN
      chk("b2b_q", quotient, 8'hEE);
      chk("b2b_r", remainder, 8'hFE);
`else
      chk("b2b_q", quotient, 8'd66);
      chk("b2b_r", remainder, 8'd2);
`endif

      issue(8'd100, 8'd7);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_q", quotient, 8'd0);
      chk("arst_r", remainder, 8'd0);
      chk("arst_dbz", div_by_zero, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("arst_nodone", pulses, 0);
      op("d50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, LAT, LAT - 1);

`ifdef SIGNED_DIV_EN
      op("sm100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT, LAT - 1);
      op("sm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, LAT - 1);
`else
      op("d156_7", 8'h9C, 8'd7, 8'd22, 8'd2, 1'b0, LAT, LAT - 1);
      op("d128_255", 8'h80, 8'hFF, 8'd0, 8'd128, 1'b0, LAT, LAT - 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
